// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment scan driver.
// Segment vectors are ordered [g,f,e,d,c,b,a], with 1 meaning the segment is lit.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        PH_BLANK,
        PH_ACTIVE
    } phase_t;

    localparam seg_t GLYPH_0   = 7'b0111111;
    localparam seg_t GLYPH_1   = 7'b0000110;
    localparam seg_t GLYPH_2   = 7'b1011011;
    localparam seg_t GLYPH_3   = 7'b1001111;
    localparam seg_t GLYPH_4   = 7'b1100110;
    localparam seg_t GLYPH_5   = 7'b1101101;
    localparam seg_t GLYPH_6   = 7'b1111101;
    localparam seg_t GLYPH_7   = 7'b0000111;
    localparam seg_t GLYPH_8   = 7'b1111111;
    localparam seg_t GLYPH_9   = 7'b1101111;
    localparam seg_t GLYPH_A   = 7'b1110111;
    localparam seg_t GLYPH_B   = 7'b1111100;
    localparam seg_t GLYPH_C   = 7'b0111001;
    localparam seg_t GLYPH_D   = 7'b1011110;
    localparam seg_t GLYPH_E   = 7'b1111001;
    localparam seg_t GLYPH_F   = 7'b1110001;
    localparam seg_t GLYPH_ERR = 7'b1000001;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 4-bit code to segment pattern decoder.
// Codes 10-15 decode as A..F in hex mode and as the error glyph otherwise.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    output seg_t       seg
);

    always_comb begin
        seg = GLYPH_ERR;
        case (code)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = hex_mode ? GLYPH_A : GLYPH_ERR;
            4'hB: seg = hex_mode ? GLYPH_B : GLYPH_ERR;
            4'hC: seg = hex_mode ? GLYPH_C : GLYPH_ERR;
            4'hD: seg = hex_mode ? GLYPH_D : GLYPH_ERR;
            4'hE: seg = hex_mode ? GLYPH_E : GLYPH_ERR;
            4'hF: seg = hex_mode ? GLYPH_F : GLYPH_ERR;
            default: seg = GLYPH_ERR;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered digit data,
// per-slot dead time, hex/decimal decode and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam phase_t PHASE_RST = (BLANK_CYCLES == 0) ? PH_ACTIVE : PH_BLANK;

    logic [CW-1:0] cnt, cnt_next;
    logic [IW-1:0] idx, idx_next;
    phase_t        phase, phase_next;
    logic          slot_end, boundary;

    logic [4*NUM_DIGITS-1:0] disp_digits, pend_digits;
    logic [NUM_DIGITS-1:0]   disp_dp, pend_dp;
    logic                    pend_v;

    logic [3:0]            cur_code;
    logic                  cur_dp, cur_blank, zero_above;
    logic [NUM_DIGITS-1:0] an_next;
    seg_t                  glyph;

    logic                  wrap_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        boundary   = slot_end && (idx == IDX_LAST);
        cnt_next   = slot_end ? '0 : cnt + 1'b1;
        idx_next   = idx;
        if (slot_end) begin
            idx_next = boundary ? '0 : idx + 1'b1;
        end
        phase_next = (int'(cnt_next) >= BLANK_CYCLES) ? PH_ACTIVE : PH_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            phase <= PHASE_RST;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            phase <= phase_next;
        end
    end

    // A load landing on the frame boundary goes straight to the display buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_digits <= '0;
            disp_dp     <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_v      <= 1'b0;
        end else if (boundary && load) begin
            disp_digits <= digits_in;
            disp_dp     <= dp_in;
            pend_v      <= 1'b0;
        end else if (boundary && pend_v) begin
            disp_digits <= pend_digits;
            disp_dp     <= pend_dp;
            pend_v      <= 1'b0;
        end else if (load) begin
            pend_digits <= digits_in;
            pend_dp     <= dp_in;
            pend_v      <= 1'b1;
        end
    end

    // Walk from the most significant digit down so zero_above tracks "this and all higher are zero".
    always_comb begin
        cur_code   = '0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        an_next    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_digits[4*k +: 4] == 4'd0);
            if (int'(idx) == k) begin
                cur_code   = disp_digits[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_blank  = lz_suppress && zero_above && (k > 0);
                an_next[k] = 1'b1;
            end
        end
    end

    seg7_glyph_decode u_decode (
        .code     (cur_code),
        .hex_mode (hex_mode),
        .seg      (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
        end else begin
            wrap_q       <= boundary;
            frame_done_q <= wrap_q;
            if (phase == PH_ACTIVE) begin
                an_q  <= an_next;
                dp_q  <= cur_dp;
                seg_q <= cur_blank ? 7'b0 : glyph;
            end else begin
                an_q  <= '0;
                dp_q  <= 1'b0;
                seg_q <= '0;
            end
        end
    end

    assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = ACTIVE_LOW ? ~dp_q  : dp_q;
    assign an         = ACTIVE_LOW ? ~an_q  : an_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display. It takes a packed vector of 4-bit digit codes and per-digit decimal points, and holds them in double-buffered registers. Digits are scanned one at a time, with a programmable dead time between slots to prevent ghosting. Glyph decoding supports a decimal mode (10–15 show the error glyph), a hex mode (A–F) and leading-zero suppression. The block sits between the datapath and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- CLK_DIV, 1000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; legal range 0..CLK_DIV-1.
- ACTIVE_LOW, 0, when 1, seg, dp and an are inverted at the pins.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  one-cycle strobe that captures digits_in and dp_in into the pending buffer.
- digits_in  in  4*NUM_DIGITS  digit codes; bits [3:0] are digit 0, the rightmost and least significant digit.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- hex_mode  in  1  1 = codes 10–15 show A,b,C,d,E,F; 0 = codes 10–15 show the error glyph.
- lz_suppress  in  1  1 = blank leading zeros.
- seg  out  7  segment bits, ordered [g,f,e,d,c,b,a].
- dp  out  1  decimal point segment.
- an  out  NUM_DIGITS  digit enable, one-hot (logical polarity is active-high).
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- **Glyph table:**
  - Digits 0–9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
  - Hex glyphs: A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - Error glyph: 1000001.
- **Buffering:**
  - `load` writes the pending buffer and sets pend_v.
  - A second `load` before the frame boundary overwrites the pending buffer (last write wins).
  - At each frame boundary with pend_v=1, pending is copied to the display buffer and pend_v is cleared.
  - `load` in the same cycle as a boundary bypasses pending: `digits_in`/`dp_in` go straight to the display buffer and pend_v ends at 0.
- **Counters:**
  - cnt counts 0..CLK_DIV-1. At cnt==CLK_DIV-1, cnt returns to 0 and idx increments.
  - idx counts 0..NUM_DIGITS-1. A frame boundary is idx==NUM_DIGITS-1 together with cnt==CLK_DIV-1.
  - At the boundary idx wraps to 0 and `frame_done` pulses.
- **Slot phase state (two states):**
  - BLANK while cnt<BLANK_CYCLES: `an` all off, `seg`=0, `dp`=0.
  - ACTIVE while cnt≥BLANK_CYCLES: an[idx]=1; `seg`/`dp` are the decode of display digit idx.
  - With BLANK_CYCLES=0 the block is always ACTIVE.
- **Leading-zero suppression:**
  - When lz_suppress=1, digit k is blanked (`seg`=0) if digits k..NUM_DIGITS-1 are all 0 and k>0.
  - Digit 0 is never suppressed.
  - `dp` is unaffected by suppression.
  - `an` still asserts for a suppressed digit.
- **Live inputs:** `hex_mode` and `lz_suppress` are sampled live, not buffered.
- **Polarity:** the ACTIVE_LOW inversion is applied after all logic.

## Timing
- **Reset values** (logical, before ACTIVE_LOW inversion): `seg`=0, `dp`=0, `an`=0, `frame_done`=0, cnt=0, idx=0, display buffer=0, pending buffer=0, pend_v=0.
- **After rst_n deasserts:** the first ACTIVE cycle shows digit 0 = "0"; higher digits show "0", or are blank when lz_suppress=1.
- **Output latency:**
  - `seg`, `dp`, `an` and `frame_done` are registered: one cycle of latency from (cnt, idx).
  - `an` never has two bits set; there is no overlap cycle between slots.
- **`frame_done` timing:** asserts in the cycle after the boundary, in the same cycle that cnt=0, idx=0 is first reflected at the outputs.
- **load-to-display latency:** from `load` at cycle t, the new digit 0 appears on the pins at the first ACTIVE output cycle of the next frame. Worst case is NUM_DIGITS*CLK_DIV+BLANK_CYCLES+1 cycles.
- **Reset mid-frame:** reset takes effect on the next clk edge; all state returns to reset values and the pending data is discarded.

## Structure
- **Package seg7_pkg:**
  - localparams for the sixteen glyphs and the error glyph.
  - A typedef for the 7-bit segment vector, bit order [g,f,e,d,c,b,a].
- **Sub-module seg7_glyph_decode:** purely combinational (code[3:0], hex_mode → seg[6:0]), instantiated once on the selected digit.
- **Widths:** cnt uses $clog2(CLK_DIV) bits; idx uses max(1,$clog2(NUM_DIGITS)) bits.

## Test plan
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=0.
- **Reset scan:** release reset and run 32 cycles → `an` follows 0000 for 2 cycles, 0001 for 6, 0000 for 2, 0010 for 6, and so on; `seg`=0111111 when active; `frame_done` pulses once per 32 cycles.
- **Decode:** load 16'h9A3F with hex_mode=0 → digits 0..3 show error, 1001111, error, 1101111; with hex_mode=1 → 1110001, 1001111, 1110111, 1101111.
- **Tear-free update:**
  - load 16'h1234 mid-frame → old data is held until `frame_done`; the new digit 0 shows 1100110 on the first ACTIVE cycle after it.
  - Two loads in one frame → only the second load is displayed.
- **Simultaneous event:** assert `load` in the boundary cycle with 16'h0005 → the next frame shows 1101101 on digit 0 and nothing remains pending.
- **Leading-zero suppression:** lz_suppress=1 with 16'h0050, dp_in=4'b1000 → digits 3 and 2 have `seg`=0 while `an` still toggles; digit 3 has `dp`=1; digit 1 shows 1101101 and digit 0 shows 0111111.
- **Reset mid-operation:** pulse rst_n low for 1 cycle at cnt=5, idx=2 → the next cycle has `an`=0 and display=0, and scanning restarts from idx 0.
